// File: rtl/dvid_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the DVI-D timing controller.
package dvid_pkg;

    // Controller run state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // 640x480@60 defaults (25.175 MHz pixel clock)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Counter width and the largest total it can represent
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2048;
    localparam int unsigned PIX_W     = 8;

    // Total clocks per line (or lines per frame) from the four timing segments
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/dvid_timing_ctrl.sv
// Pixel-clock timing generator: counters, source request and a 2-stage
// registered output pipeline feeding the TMDS encoders.
module dvid_timing_ctrl
    import dvid_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk_vga,
    input  logic             reset,
    input  logic             enable,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    input  logic [PIX_W-1:0] rgb_r,
    input  logic [PIX_W-1:0] rgb_g,
    input  logic [PIX_W-1:0] rgb_b,
    output logic [PIX_W-1:0] red,
    output logic [PIX_W-1:0] green,
    output logic [PIX_W-1:0] blue,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Compare one bit wider so a sync end equal to 2048 does not alias to 0
    localparam int unsigned CMP_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] L_H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CMP_W-1:0] L_H_ACT    = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] L_V_ACT    = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] L_HS_START = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] L_HS_END   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] L_VS_START = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] L_VS_END   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject timings the 11-bit counters cannot hold
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("dvid_timing_ctrl: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("dvid_timing_ctrl: V_TOTAL exceeds 2048");
    end

    state_e           r_state;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    logic             w_run;
    logic [CMP_W-1:0] w_h_ext;
    logic [CMP_W-1:0] w_v_ext;
    logic             w_active;
    logic             w_hs_region;
    logic             w_vs_region;
    logic             w_first;

    logic             r_act1;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_first1;

    logic             r_blank;
    logic             r_hsync;
    logic             r_vsync;
    logic [PIX_W-1:0] r_red;
    logic [PIX_W-1:0] r_green;
    logic [PIX_W-1:0] r_blue;
    logic             r_frame_start;

    // Run/idle state and raster counters; leaving RUN clears the counters
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_h     <= '0;
                        r_v     <= '0;
                    end else if (r_h == L_H_LAST) begin
                        r_h <= '0;
                        if (r_v == L_V_LAST) begin
                            r_v <= '0;
                        end else begin
                            r_v <= r_v + CNT_W'(1);
                        end
                    end else begin
                        r_h <= r_h + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_h     <= '0;
                    r_v     <= '0;
                end
            endcase
        end
    end

    // Stage 0: region decode straight from the counter registers
    assign w_run       = (r_state == RUN);
    assign w_h_ext     = {1'b0, r_h};
    assign w_v_ext     = {1'b0, r_v};
    assign w_active    = w_run && (w_h_ext < L_H_ACT) && (w_v_ext < L_V_ACT);
    assign w_hs_region = w_run && (w_h_ext >= L_HS_START) && (w_h_ext < L_HS_END);
    assign w_vs_region = w_run && (w_v_ext >= L_VS_START) && (w_v_ext < L_VS_END);
    assign w_first     = w_run && (r_h == '0) && (r_v == '0);

    assign pix_req = w_active;
    assign pix_x   = r_h;
    assign pix_y   = r_v;

    // Stage 1: hold the decode for the cycle in which source data is fetched
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_act1   <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_first1 <= 1'b0;
        end else begin
            r_act1   <= w_active;
            r_hs1    <= w_hs_region;
            r_vs1    <= w_vs_region;
            r_first1 <= w_first;
        end
    end

    // Stage 2: aligned encoder outputs; pixel data forced to black when blanked
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r_blank       <= 1'b1;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_blank       <= ~r_act1;
            r_hsync       <= r_hs1 ? HS_POL : ~HS_POL;
            r_vsync       <= r_vs1 ? VS_POL : ~VS_POL;
            r_red         <= r_act1 ? rgb_r : '0;
            r_green       <= r_act1 ? rgb_g : '0;
            r_blue        <= r_act1 ? rgb_b : '0;
            r_frame_start <= r_first1;
        end
    end

    assign blank       = r_blank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_dvid_timing_ctrl.sv
// Directed bench: a reduced-timing instance driven from a vector table,
// plus a default 640x480 instance checked with hand-written sequences.
module tb_dvid_timing_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    // Default-timing instance
    logic        d_req, d_hs, d_vs, d_blank, d_fs;
    logic [10:0] d_x, d_y;
    logic [7:0]  d_sr, d_sg, d_sb, d_r, d_g, d_b;

    dvid_timing_ctrl u_dut (
        .clk_vga(clk), .reset(rst), .enable(en),
        .pix_req(d_req), .pix_x(d_x), .pix_y(d_y),
        .rgb_r(d_sr), .rgb_g(d_sg), .rgb_b(d_sb),
        .red(d_r), .green(d_g), .blue(d_b),
        .hsync(d_hs), .vsync(d_vs), .blank(d_blank), .frame_start(d_fs)
    );

    // Reduced-timing instance: 32 clocks x 13 lines, vsync active high
    logic        s_req, s_hs, s_vs, s_blank, s_fs;
    logic [10:0] s_x, s_y;
    logic [7:0]  s_sr, s_sg, s_sb, s_r, s_g, s_b;

    dvid_timing_ctrl #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_small (
        .clk_vga(clk), .reset(rst), .enable(en),
        .pix_req(s_req), .pix_x(s_x), .pix_y(s_y),
        .rgb_r(s_sr), .rgb_g(s_sg), .rgb_b(s_sb),
        .red(s_r), .green(s_g), .blue(s_b),
        .hsync(s_hs), .vsync(s_vs), .blank(s_blank), .frame_start(s_fs)
    );

    // Source models: one-cycle registered lookup of the requested coordinate
    always @(posedge clk) begin
        d_sr <= d_x[7:0];
        d_sg <= d_y[7:0];
        d_sb <= d_x[7:0] ^ d_y[7:0];
        s_sr <= s_x[7:0];
        s_sg <= s_y[7:0];
        s_sb <= s_x[7:0] ^ s_y[7:0];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic en;
        int   adv;
        logic req;
        int   x;
        int   y;
        logic blank;
        logic hs;
        logic vs;
        int   red;
        int   grn;
        logic fs;
    } vec_t;

    function automatic vec_t mk(input logic e, input int a, input logic rq, input int x, input int y,
                                input logic bl, input logic hs, input logic vs,
                                input int r, input int g, input logic fs);
        vec_t v;
        v.en = e; v.adv = a; v.req = rq; v.x = x; v.y = y;
        v.blank = bl; v.hs = hs; v.vs = vs; v.red = r; v.grn = g; v.fs = fs;
        return v;
    endfunction

    vec_t vt[23];

    int hs_low, hs_first, bl_cnt, rgb_bad, fs_cnt, fs_bad, vs_hi, vs_first;

    initial begin
        // Reduced instance; k = clock edges since the first RUN edge
        //            en adv req  x  y bl hs vs red grn fs
        vt[0]  = mk(0,  2, 0,  0, 0, 1, 1, 0,  0, 0, 0); // idle after reset
        vt[1]  = mk(1,  1, 1,  0, 0, 1, 1, 0,  0, 0, 0); // k=0 first RUN cycle
        vt[2]  = mk(1,  1, 1,  1, 0, 1, 1, 0,  0, 0, 0); // k=1
        vt[3]  = mk(1,  1, 1,  2, 0, 0, 1, 0,  0, 0, 1); // k=2 out (0,0)
        vt[4]  = mk(1,  1, 1,  3, 0, 0, 1, 0,  1, 0, 0); // out (1,0)
        vt[5]  = mk(1, 18, 0, 21, 0, 0, 1, 0, 19, 0, 0); // last active output
        vt[6]  = mk(1,  1, 0, 22, 0, 1, 1, 0,  0, 0, 0); // out h=20 blanked
        vt[7]  = mk(1,  3, 0, 25, 0, 1, 0, 0,  0, 0, 0); // out h=23 hsync start
        vt[8]  = mk(1,  5, 0, 30, 0, 1, 1, 0,  0, 0, 0); // out h=28 hsync end
        vt[9]  = mk(1,  2, 1,  0, 1, 1, 1, 0,  0, 0, 0); // line wrap
        vt[10] = mk(1,  4, 1,  4, 1, 0, 1, 0,  2, 1, 0); // out (2,1)
        vt[11] = mk(1,220, 0,  0, 8, 1, 1, 0,  0, 0, 0); // counter at (0,8)
        vt[12] = mk(1,  2, 0,  2, 8, 1, 1, 1,  0, 0, 0); // vsync at out (0,8)
        vt[13] = mk(1, 64, 0,  2,10, 1, 1, 0,  0, 0, 0); // vsync ends out (0,10)
        vt[14] = mk(1, 94, 1,  0, 0, 1, 1, 0,  0, 0, 0); // frame wrap
        vt[15] = mk(1,  2, 1,  2, 0, 0, 1, 0,  0, 0, 1); // second frame_start
        vt[16] = mk(1,  1, 1,  3, 0, 0, 1, 0,  1, 0, 0);
        vt[17] = mk(0,  1, 0,  0, 0, 0, 1, 0,  2, 0, 0); // enable drop: in flight
        vt[18] = mk(0,  1, 0,  0, 0, 0, 1, 0,  3, 0, 0); // last in-flight pixel
        vt[19] = mk(0,  1, 0,  0, 0, 1, 1, 0,  0, 0, 0); // idle by E+2
        vt[20] = mk(0,  3, 0,  0, 0, 1, 1, 0,  0, 0, 0); // held idle
        vt[21] = mk(1,  1, 1,  0, 0, 1, 1, 0,  0, 0, 0); // restart at (0,0)
        vt[22] = mk(1,  2, 1,  2, 0, 0, 1, 0,  0, 0, 1); // frame_start on restart

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            en = vt[i].en;
            repeat (vt[i].adv) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d.pix_req", i), 32'(s_req),   32'(vt[i].req));
            chk($sformatf("v%0d.pix_x", i),   32'(s_x),     32'(vt[i].x));
            chk($sformatf("v%0d.pix_y", i),   32'(s_y),     32'(vt[i].y));
            chk($sformatf("v%0d.blank", i),   32'(s_blank), 32'(vt[i].blank));
            chk($sformatf("v%0d.hsync", i),   32'(s_hs),    32'(vt[i].hs));
            chk($sformatf("v%0d.vsync", i),   32'(s_vs),    32'(vt[i].vs));
            chk($sformatf("v%0d.red", i),     32'(s_r),     32'(vt[i].red));
            chk($sformatf("v%0d.green", i),   32'(s_g),     32'(vt[i].grn));
            chk($sformatf("v%0d.fs", i),      32'(s_fs),    32'(vt[i].fs));
        end

        // Default instance: reset state held with enable low
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst.blank", 32'(d_blank), 32'd1);
        chk("rst.hsync", 32'(d_hs), 32'd1);
        chk("rst.vsync", 32'(d_vs), 32'd1);
        chk("rst.rgb", 32'({d_r, d_g, d_b}), 32'd0);
        chk("rst.pix_req", 32'(d_req), 32'd0);
        chk("rst.pix_xy", 32'({d_x, d_y}), 32'd0);
        chk("rst.fs", 32'(d_fs), 32'd0);

        // Default instance: run ~2 lines and measure per-line timing
        hs_low = 0; hs_first = -1; bl_cnt = 0; rgb_bad = 0;
        fs_cnt = 0; fs_bad = 0; vs_hi = 0; vs_first = -1;
        en = 1'b1;
        for (int k = 0; k < 1700; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin
                chk("run.first_req", 32'(d_req), 32'd1);
                chk("run.first_xy", 32'({d_x, d_y}), 32'd0);
            end
            if (k == 2) chk("run.fs_k2", 32'(d_fs), 32'd1);
            if (k == 3) chk("run.fs_k3", 32'(d_fs), 32'd0);
            if (k < 800 && !d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (k >= 2 && k < 802 && d_blank) bl_cnt++;
            if (d_blank && ({d_r, d_g, d_b} != 24'd0)) rgb_bad++;
            if (k == 1102) begin
                chk("pix300_1.red", 32'(d_r), 32'd44);
                chk("pix300_1.green", 32'(d_g), 32'd1);
                chk("pix300_1.blue", 32'(d_b), 32'(8'd44 ^ 8'd1));
                chk("pix300_1.y", 32'(d_y), 32'd1);
            end
            if (s_fs) begin
                fs_cnt++;
                if ((k - 2) % 416 != 0) fs_bad++;
            end
            if (k < 416 && s_vs) begin
                vs_hi++;
                if (vs_first < 0) vs_first = k;
            end
        end
        chk("line.hsync_start", 32'(hs_first), 32'd658);
        chk("line.hsync_len", 32'(hs_low), 32'd96);
        chk("line.blank_cnt", 32'(bl_cnt), 32'd160);
        chk("line.rgb_in_blank", 32'(rgb_bad), 32'd0);
        chk("small.fs_count", 32'(fs_cnt), 32'd5);
        chk("small.fs_period", 32'(fs_bad), 32'd0);
        chk("small.vsync_start", 32'(vs_first), 32'd258);
        chk("small.vsync_len", 32'(vs_hi), 32'd64);

        // Mid-line asynchronous reset: outputs clear before any clock edge
        chk("pre_rst.blank", 32'(d_blank), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.blank", 32'(d_blank), 32'd1);
        chk("arst.hsync", 32'(d_hs), 32'd1);
        chk("arst.vsync", 32'(d_vs), 32'd1);
        chk("arst.rgb", 32'({d_r, d_g, d_b}), 32'd0);
        chk("arst.pix_req", 32'(d_req), 32'd0);
        chk("arst.pix_x", 32'(d_x), 32'd0);
        chk("arst.small_vsync", 32'(s_vs), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst.idle_req", 32'(d_req), 32'd0);
        chk("post_rst.idle_blank", 32'(d_blank), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
